// File: rtl/mc_pkg.sv
// mc_pkg: constants shared by the multi-cycle controller.
//   state_e     : FSM state codes (also driven out on the 4-bit state port)
//   Alu*        : 3-bit ALUControl operation codes
//   Fn*         : Funct[4:1] opcode values recognised by the ALU decoder
//   IsMulPat    : Instr[7:4] value that marks a multiply
package mc_pkg;

   typedef enum logic [3:0] {
      StFetch   = 4'd0,
      StDecode  = 4'd1,
      StMemAdr  = 4'd2,
      StMemRead = 4'd3,
      StMemWb   = 4'd4,
      StMemWr   = 4'd5,
      StExecR   = 4'd6,
      StExecI   = 4'd7,
      StAluWb   = 4'd8,
      StBranch  = 4'd9,
      StMulExec = 4'd10,
      StMulWait = 4'd11
   } state_e;

   localparam logic [2:0] AluAdd = 3'b000;
   localparam logic [2:0] AluSub = 3'b001;
   localparam logic [2:0] AluAnd = 3'b010;
   localparam logic [2:0] AluOrr = 3'b011;
   localparam logic [2:0] AluMul = 3'b100;
   localparam logic [2:0] AluEor = 3'b101;
   localparam logic [2:0] AluMov = 3'b110;

   localparam logic [3:0] FnAnd = 4'b0000;
   localparam logic [3:0] FnEor = 4'b0001;
   localparam logic [3:0] FnSub = 4'b0010;
   localparam logic [3:0] FnAdd = 4'b0100;
   localparam logic [3:0] FnTst = 4'b1000;
   localparam logic [3:0] FnCmp = 4'b1010;
   localparam logic [3:0] FnOrr = 4'b1100;
   localparam logic [3:0] FnMov = 4'b1101;

   localparam logic [3:0] IsMulPat = 4'b1001;

endpackage

// File: rtl/mc_alu_dec.sv
// mc_alu_dec: ALU operation / flag-write decoder for mc_control.
// Optional multiply decode is compiled in with MC_CONTROL_MUL_EN.
//   i_alu_op       : decoder enable (FSM is in an ALU state)
//   i_op, i_funct  : Instr[27:26], Instr[25:20]
//   i_is_mul       : Instr[7:4]
//   o_alu_control  : operation code, zero-extended to ALUCTRL_W
//   o_flag_w       : flag write enables {NZ, CV}
//   o_op_mul       : instruction is a multiply (state independent)
//   o_no_wb        : instruction is CMP/TST, so no register write-back
module mc_alu_dec #(
   parameter int unsigned ALUCTRL_W = 3
) (
   input  logic                 i_alu_op,
   input  logic [1:0]           i_op,
   input  logic [5:0]           i_funct,
   input  logic [3:0]           i_is_mul,
   output logic [ALUCTRL_W-1:0] o_alu_control,
   output logic [1:0]           o_flag_w,
   output logic                 o_op_mul,
   output logic                 o_no_wb
);
   import mc_pkg::*;

   logic [2:0] w_code;
   logic       w_arith;   // op updates C/V flags
   logic       w_cmp_tst;
   logic       w_op_mul;

`ifdef MC_CONTROL_MUL_EN
   assign w_op_mul = (i_op == 2'b00) && (i_funct[5:4] == 2'b00) && (i_is_mul == IsMulPat);
`else
   logic w_unused;
   assign w_op_mul = 1'b0;
   assign w_unused = ^{i_op, i_is_mul, i_funct[5]};
`endif

   always_comb begin
      w_code    = AluAdd;
      w_arith   = 1'b0;
      w_cmp_tst = 1'b0;
      case (i_funct[4:1])
         FnAdd: begin w_code = AluAdd; w_arith = 1'b1; end
         FnSub: begin w_code = AluSub; w_arith = 1'b1; end
         FnAnd: begin
            if (w_op_mul) begin
               w_code  = AluMul;
               w_arith = 1'b1;
            end else begin
               w_code  = AluAnd;
            end
         end
         FnOrr: w_code = AluOrr;
         FnEor: w_code = AluEor;
         FnMov: w_code = AluMov;
         FnCmp: begin w_code = AluSub; w_arith = 1'b1; w_cmp_tst = 1'b1; end
         FnTst: begin w_code = AluAnd; w_cmp_tst = 1'b1; end
         default: w_code = AluAdd;
      endcase
   end

   always_comb begin
      o_alu_control = '0;
      o_flag_w      = 2'b00;
      if (i_alu_op) begin
         o_alu_control = ALUCTRL_W'(w_code);
         o_flag_w[1]   = i_funct[0] | w_cmp_tst;
         o_flag_w[0]   = i_funct[0] & w_arith;
      end
   end

   assign o_op_mul = w_op_mul;
   assign o_no_wb  = w_cmp_tst;

endmodule

// File: rtl/mc_control.sv
// mc_control: multi-cycle processor main controller (Moore FSM + ALU decode).
// Optional feature macro: MC_CONTROL_MUL_EN (adds MULEXEC/MULWAIT, timeout, MulErr).
//   clk, reset               : clock, synchronous active-high reset
//   Op, Funct, Rd, IsMul     : instruction fields
//   MulDone                  : multiplier result valid (looked at in MULWAIT only)
//   PCS, NextPC, RegW, MemW  : to condlogic
//   IRWrite, AdrSrc, ALUSrcA, ResultSrc, ALUSrcB : datapath controls
//   FlagW, ALUControl, ImmSrc, RegSrc            : decode outputs
//   opMul, MulStart, MulErr, state               : multiply status, current state code
module mc_control #(
   parameter int unsigned ALUCTRL_W   = 3,
   parameter int unsigned MUL_TIMEOUT = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [1:0]           Op,
   input  logic [5:0]           Funct,
   input  logic [3:0]           Rd,
   input  logic [3:0]           IsMul,
   input  logic                 MulDone,
   output logic                 PCS,
   output logic                 NextPC,
   output logic                 RegW,
   output logic                 MemW,
   output logic                 IRWrite,
   output logic                 AdrSrc,
   output logic                 ALUSrcA,
   output logic [1:0]           ResultSrc,
   output logic [1:0]           ALUSrcB,
   output logic [1:0]           FlagW,
   output logic [ALUCTRL_W-1:0] ALUControl,
   output logic [1:0]           ImmSrc,
   output logic [1:0]           RegSrc,
   output logic                 opMul,
   output logic                 MulStart,
   output logic                 MulErr,
   output logic [3:0]           state
);
   import mc_pkg::*;

   state_e r_state, w_state_next;
   logic   w_irwrite, w_nextpc, w_regw, w_memw, w_branch, w_alu_op;
   logic   w_op_mul, w_no_wb;

   mc_alu_dec #(
      .ALUCTRL_W (ALUCTRL_W)
   ) u_alu_dec (
      .i_alu_op      (w_alu_op),
      .i_op          (Op),
      .i_funct       (Funct),
      .i_is_mul      (IsMul),
      .o_alu_control (ALUControl),
      .o_flag_w      (FlagW),
      .o_op_mul      (w_op_mul),
      .o_no_wb       (w_no_wb)
   );

`ifdef MC_CONTROL_MUL_EN
   localparam logic [7:0] TimeoutLast = 8'(MUL_TIMEOUT - 1);
   logic [7:0] r_cnt, w_cnt_next;
   logic       r_mul_err, w_mul_err_next;
   logic       w_mul_start;
`else
   logic w_unused;
   assign w_unused = MulDone ^ (MUL_TIMEOUT == 32'd0);
`endif

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= StFetch;
`ifdef MC_CONTROL_MUL_EN
         r_cnt     <= '0;
         r_mul_err <= 1'b0;
`endif
      end else begin
         r_state   <= w_state_next;
`ifdef MC_CONTROL_MUL_EN
         r_cnt     <= w_cnt_next;
         r_mul_err <= w_mul_err_next;
`endif
      end
   end

   // Next-state logic
   always_comb begin
      w_state_next = StFetch;
`ifdef MC_CONTROL_MUL_EN
      w_cnt_next     = r_cnt;
      w_mul_err_next = r_mul_err;
`endif
      case (r_state)
         StFetch:   w_state_next = StDecode;
         StDecode: begin
            case (Op)
               2'b01: w_state_next = StMemAdr;
               2'b00: begin
                  w_state_next = Funct[5] ? StExecI : StExecR;
`ifdef MC_CONTROL_MUL_EN
                  if (w_op_mul) w_state_next = StMulExec;
`endif
               end
               2'b10: w_state_next = StBranch;
               default: w_state_next = StFetch;
            endcase
         end
         StMemAdr:  w_state_next = Funct[0] ? StMemRead : StMemWr;
         StMemRead: w_state_next = StMemWb;
         StExecR:   w_state_next = StAluWb;
         StExecI:   w_state_next = StAluWb;
`ifdef MC_CONTROL_MUL_EN
         StMulExec: begin
            w_state_next = StMulWait;
            w_cnt_next   = '0;
         end
         StMulWait: begin
            // MulDone wins even on the last permitted cycle
            if (MulDone) begin
               w_state_next = StAluWb;
            end else if (r_cnt == TimeoutLast) begin
               w_state_next   = StFetch;
               w_mul_err_next = 1'b1;
            end else begin
               w_state_next = StMulWait;
               w_cnt_next   = r_cnt + 8'd1;
            end
         end
`endif
         default:   w_state_next = StFetch;
      endcase
   end

   // Moore outputs
   always_comb begin
      w_irwrite = 1'b0;
      w_nextpc  = 1'b0;
      w_regw    = 1'b0;
      w_memw    = 1'b0;
      w_branch  = 1'b0;
      w_alu_op  = 1'b0;
      AdrSrc    = 1'b0;
      ALUSrcA   = 1'b0;
      ALUSrcB   = 2'b00;
      ResultSrc = 2'b00;
`ifdef MC_CONTROL_MUL_EN
      w_mul_start = 1'b0;
`endif
      case (r_state)
         StFetch: begin
            w_irwrite = 1'b1;
            w_nextpc  = 1'b1;
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
         end
         StDecode: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
         end
         StMemAdr:  ALUSrcB = 2'b01;
         StBranch: begin
            ALUSrcB   = 2'b01;
            ResultSrc = 2'b10;
            w_branch  = 1'b1;
         end
         StMemRead: AdrSrc = 1'b1;
         StMemWr: begin
            AdrSrc = 1'b1;
            w_memw = 1'b1;
         end
         StMemWb: begin
            ResultSrc = 2'b01;
            w_regw    = 1'b1;
         end
         StExecR:   w_alu_op = 1'b1;
         StExecI: begin
            ALUSrcB  = 2'b01;
            w_alu_op = 1'b1;
         end
         StAluWb:   w_regw = ~w_no_wb;
`ifdef MC_CONTROL_MUL_EN
         StMulExec: begin
            w_mul_start = 1'b1;
            w_alu_op    = 1'b1;
         end
         StMulWait: w_alu_op = 1'b1;
`endif
         default: ;
      endcase
   end

   // Side-effecting strobes are held off for the whole reset cycle
   assign IRWrite = w_irwrite & ~reset;
   assign NextPC  = w_nextpc & ~reset;
   assign RegW    = w_regw & ~reset;
   assign MemW    = w_memw & ~reset;
   assign PCS     = ((Rd == 4'hF) & RegW) | w_branch;
   assign ImmSrc  = Op;
   assign RegSrc  = {Op == 2'b01, Op == 2'b10};
   assign opMul   = w_op_mul;
   assign state   = r_state;

`ifdef MC_CONTROL_MUL_EN
   assign MulStart = w_mul_start & ~reset;
   assign MulErr   = r_mul_err;
`else
   assign MulStart = 1'b0;
   assign MulErr   = 1'b0;
`endif

endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: self-checking bench for mc_control (table vectors, hand-written
// reset/timeout sequences, randomized instructions against a path-level model).
module tb_mc_control;

   localparam int unsigned AW = 4;    // wider than 3 to exercise zero-extension
   localparam int unsigned TO = 16;
`ifdef MC_CONTROL_MUL_EN
   localparam bit MulEn = 1'b1;
`else
   localparam bit MulEn = 1'b0;
`endif

   typedef struct packed {
      logic          pcs, npc, regw, memw, irw, adr, srca;
      logic [1:0]    res, srcb, flagw;
      logic [AW-1:0] alu;
      logic [1:0]    imm, regsrc;
      logic          opmul, mst, merr;
   } ovec_t;

   typedef struct {
      string       name;
      logic [1:0]  op;
      logic [5:0]  funct;
      logic [3:0]  ismul;
      logic [3:0]  rd;
      int          done_at;
      int          len;
      logic [63:0] seq;    // state i in nibble i
      int          ci;     // checkpoint index into the sequence
      logic [1:0]  fw;
      logic [2:0]  alu;
      logic        regw;
   } vec_t;

   logic clk, reset, MulDone;
   logic [1:0] Op;
   logic [5:0] Funct;
   logic [3:0] Rd, IsMul;
   logic PCS, NextPC, RegW, MemW, IRWrite, AdrSrc, ALUSrcA, opMul, MulStart, MulErr;
   logic [1:0] ResultSrc, ALUSrcB, FlagW, ImmSrc, RegSrc;
   logic [AW-1:0] ALUControl;
   logic [3:0] state;
   ovec_t w_ov;

   int total = 0;
   int bad = 0;
   int path[$];
   logic [3:0] obs_st [64];
   ovec_t      obs_ov [64];
   int obs_n;
   logic m_err = 1'b0;
   logic [2:0] code_tab [16];
   logic       arith_tab [16];
   vec_t vt[$];

   mc_control #(
      .ALUCTRL_W   (AW),
      .MUL_TIMEOUT (TO)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .Op         (Op),
      .Funct      (Funct),
      .Rd         (Rd),
      .IsMul      (IsMul),
      .MulDone    (MulDone),
      .PCS        (PCS),
      .NextPC     (NextPC),
      .RegW       (RegW),
      .MemW       (MemW),
      .IRWrite    (IRWrite),
      .AdrSrc     (AdrSrc),
      .ALUSrcA    (ALUSrcA),
      .ResultSrc  (ResultSrc),
      .ALUSrcB    (ALUSrcB),
      .FlagW      (FlagW),
      .ALUControl (ALUControl),
      .ImmSrc     (ImmSrc),
      .RegSrc     (RegSrc),
      .opMul      (opMul),
      .MulStart   (MulStart),
      .MulErr     (MulErr),
      .state      (state)
   );

   assign w_ov = {PCS, NextPC, RegW, MemW, IRWrite, AdrSrc, ALUSrcA, ResultSrc, ALUSrcB,
                  FlagW, ALUControl, ImmSrc, RegSrc, opMul, MulStart, MulErr};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h required %0h (t=%0t)", nm, got, exp, $time);
      end
   endtask

   function automatic logic mul_pat(input logic [1:0] op, input logic [5:0] fn,
                                    input logic [3:0] ismul);
      return MulEn && op == 2'b00 && fn[5:4] == 2'b00 && ismul == 4'b1001;
   endfunction

   // Expected state path of one instruction, starting at FETCH
   task automatic build_path(input logic [1:0] op, input logic [5:0] fn,
                             input logic [3:0] ismul, input int done_at);
      int k;
      path.delete();
      path.push_back(0);
      path.push_back(1);
      if (op == 2'b01) begin
         path.push_back(2);
         if (fn[0]) begin path.push_back(3); path.push_back(4); end
         else path.push_back(5);
      end else if (op == 2'b10) begin
         path.push_back(9);
      end else if (op == 2'b00) begin
         if (mul_pat(op, fn, ismul)) begin
            path.push_back(10);
            k = (done_at >= 1 && done_at <= int'(TO)) ? done_at : int'(TO);
            repeat (k) path.push_back(11);
            if (done_at >= 1 && done_at <= int'(TO)) path.push_back(8);
         end else begin
            path.push_back(fn[5] ? 7 : 6);
            path.push_back(8);
         end
      end
   endtask

   function automatic ovec_t ref_out(input logic [3:0] st, input logic [1:0] op,
                                     input logic [5:0] fn, input logic [3:0] rd,
                                     input logic [3:0] ismul, input logic rst,
                                     input logic err);
      ovec_t o;
      logic mul, cmptst, arith, alu_on, br;
      logic [2:0] code;
      int idx;
      o = '0;
      br = 1'b0;
      mul = mul_pat(op, fn, ismul);
      idx = int'(fn[4:1]);
      code = (idx == 0 && mul) ? 3'd4 : code_tab[idx];
      arith = arith_tab[idx] || (idx == 0 && mul);
      cmptst = (idx == 10) || (idx == 8);
      alu_on = (st == 6) || (st == 7) || (st == 10) || (st == 11);
      case (st)
         4'd0: begin o.irw = 1; o.npc = 1; o.srca = 1; o.srcb = 2; o.res = 2; end
         4'd1: begin o.srca = 1; o.srcb = 2; o.res = 2; end
         4'd2: o.srcb = 1;
         4'd3: o.adr = 1;
         4'd4: begin o.res = 1; o.regw = 1; end
         4'd5: begin o.adr = 1; o.memw = 1; end
         4'd7: o.srcb = 1;
         4'd8: o.regw = !cmptst;
         4'd9: begin o.srcb = 1; o.res = 2; br = 1; end
         4'd10: o.mst = 1;
         default: ;
      endcase
      if (alu_on) begin
         o.alu = AW'(code);
         o.flagw = {fn[0] | cmptst, fn[0] & arith};
      end
      if (rst) begin o.irw = 0; o.npc = 0; o.regw = 0; o.memw = 0; o.mst = 0; end
      o.pcs = (rd == 4'hF && o.regw) || br;
      o.imm = op;
      o.regsrc = {op == 2'b01, op == 2'b10};
      o.opmul = mul;
      o.merr = err;
      return o;
   endfunction

   // Entered and left at posedge+1 with the DUT in FETCH
   task automatic exec_instr(input logic [1:0] op, input logic [5:0] fn, input logic [3:0] rd,
                             input logic [3:0] ismul, input int done_at);
      int waits;
      ovec_t e;
      Op = op; Funct = fn; Rd = rd; IsMul = ismul;
      build_path(op, fn, ismul, done_at);
      waits = 0;
      obs_n = 0;
      foreach (path[i]) begin
         #1;
         if (path[i] == 11) waits++;
         e = ref_out(4'(path[i]), op, fn, rd, ismul, 1'b0, m_err);
         chk("state", 64'(state), 64'(path[i]));
         chk("outputs", 64'(w_ov), 64'(e));
         obs_st[obs_n] = state;
         obs_ov[obs_n] = w_ov;
         obs_n++;
         if (path[i] == 11 && i == path.size() - 1) m_err = 1'b1;
         MulDone = (path[i] == 11) ? (waits == done_at) : 1'($urandom);
         @(posedge clk);
         #1;
      end
   endtask

   // Run an instruction to path index k, then reset for one cycle
   task automatic reset_abort(input logic [1:0] op, input logic [5:0] fn,
                              input logic [3:0] ismul, input int k);
      Op = op; Funct = fn; Rd = 4'h0; IsMul = ismul; MulDone = 1'b0;
      build_path(op, fn, ismul, 0);
      for (int i = 0; i < k; i++) begin @(posedge clk); #1; end
      #1;
      chk("pre_reset_state", 64'(state), 64'(path[k]));
      reset = 1'b1;
      #1;
      chk("reset_gate", 64'({IRWrite, NextPC, RegW, MemW, MulStart}), 64'(0));
      @(posedge clk);
      #1;
      m_err = 1'b0;
      chk("reset_state", 64'(state), 64'(0));
      chk("reset_outputs", 64'(w_ov), 64'(ref_out(4'd0, op, fn, 4'h0, ismul, 1'b1, 1'b0)));
      reset = 1'b0;
      #1;
      chk("post_reset_fetch", 64'(w_ov), 64'(ref_out(4'd0, op, fn, 4'h0, ismul, 1'b0, 1'b0)));
      @(posedge clk);
      #1;
      chk("post_reset_decode", 64'(state), 64'(1));
      Op = 2'b11;
      @(posedge clk);
      #1;
      chk("back_to_fetch", 64'(state), 64'(0));
   endtask

   initial begin
      logic [63:0] got;
      int n_mst;
      for (int i = 0; i < 16; i++) begin code_tab[i] = 3'd0; arith_tab[i] = 1'b0; end
      code_tab[4] = 3'd0;  arith_tab[4] = 1'b1;     // ADD
      code_tab[2] = 3'd1;  arith_tab[2] = 1'b1;     // SUB
      code_tab[0] = 3'd2;                           // AND
      code_tab[12] = 3'd3;                          // ORR
      code_tab[1] = 3'd5;                           // EOR
      code_tab[13] = 3'd6;                          // MOV
      code_tab[10] = 3'd1; arith_tab[10] = 1'b1;    // CMP
      code_tab[8] = 3'd2;                           // TST

      vt.push_back('{"LDR",   2'b01, 6'b011001, 4'h0, 4'h0, 0, 5, 64'h43210, 4, 2'b00, 3'd0, 1'b1});
      vt.push_back('{"STR",   2'b01, 6'b011000, 4'h0, 4'h0, 0, 4, 64'h5210,  3, 2'b00, 3'd0, 1'b0});
      vt.push_back('{"ADDS",  2'b00, 6'b001001, 4'h0, 4'h0, 0, 4, 64'h8610,  2, 2'b11, 3'd0, 1'b0});
      vt.push_back('{"CMPI_wb", 2'b00, 6'b110101, 4'h0, 4'h0, 0, 4, 64'h8710, 3, 2'b00, 3'd0, 1'b0});
      vt.push_back('{"CMPI_fl", 2'b00, 6'b110101, 4'h0, 4'h0, 0, 4, 64'h8710, 2, 2'b11, 3'd1, 1'b0});
      vt.push_back('{"TST",   2'b00, 6'b010001, 4'h0, 4'h0, 0, 4, 64'h8610,  2, 2'b10, 3'd2, 1'b0});
      vt.push_back('{"SUB",   2'b00, 6'b000100, 4'h0, 4'h0, 0, 4, 64'h8610,  2, 2'b00, 3'd1, 1'b0});
      vt.push_back('{"MOVI",  2'b00, 6'b111010, 4'h0, 4'h0, 0, 4, 64'h8710,  2, 2'b00, 3'd6, 1'b0});
      vt.push_back('{"ORRS",  2'b00, 6'b011001, 4'h0, 4'h0, 0, 4, 64'h8610,  2, 2'b10, 3'd3, 1'b0});
      vt.push_back('{"EOR",   2'b00, 6'b000010, 4'h0, 4'h0, 0, 4, 64'h8610,  2, 2'b00, 3'd5, 1'b0});
      vt.push_back('{"UNDEF", 2'b00, 6'b001100, 4'h0, 4'h0, 0, 4, 64'h8610,  2, 2'b00, 3'd0, 1'b0});
      vt.push_back('{"B",     2'b10, 6'b000000, 4'h0, 4'h0, 0, 3, 64'h910,   2, 2'b00, 3'd0, 1'b0});
      vt.push_back('{"OP11",  2'b11, 6'b000000, 4'h0, 4'h0, 0, 2, 64'h10,    1, 2'b00, 3'd0, 1'b0});
      vt.push_back('{"ADDPC", 2'b00, 6'b001000, 4'h0, 4'hF, 0, 4, 64'h8610,  3, 2'b00, 3'd0, 1'b1});
      vt.push_back('{"ANDnm", 2'b00, 6'b000000, 4'h8, 4'h0, 0, 4, 64'h8610,  2, 2'b00, 3'd2, 1'b0});
`ifdef MC_CONTROL_MUL_EN
      vt.push_back('{"MUL",   2'b00, 6'b000000, 4'h9, 4'h0, 3, 7, 64'h8BBBA10, 2, 2'b00, 3'd4, 1'b0});
      vt.push_back('{"MULS",  2'b00, 6'b000001, 4'h9, 4'h0, 1, 5, 64'h8BA10,   2, 2'b11, 3'd4, 1'b0});
`else
      vt.push_back('{"MUL",   2'b00, 6'b000000, 4'h9, 4'h0, 3, 4, 64'h8610,  2, 2'b00, 3'd2, 1'b0});
      vt.push_back('{"MULS",  2'b00, 6'b000001, 4'h9, 4'h0, 1, 4, 64'h8610,  2, 2'b10, 3'd2, 1'b0});
`endif

      // Reset phase: FETCH with strobes forced low
      reset = 1'b1; MulDone = 1'b0; Op = 2'b01; Funct = 6'b011001; Rd = 4'hF; IsMul = 4'h9;
      repeat (2) @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         chk("rst_state", 64'(state), 64'(0));
         chk("rst_outputs", 64'(w_ov), 64'(ref_out(4'd0, Op, Funct, Rd, IsMul, 1'b1, 1'b0)));
      end
      reset = 1'b0;

      foreach (vt[v]) begin
         exec_instr(vt[v].op, vt[v].funct, vt[v].rd, vt[v].ismul, vt[v].done_at);
         got = '0;
         for (int i = 0; i < obs_n && i < 16; i++) got[4*i +: 4] = obs_st[i];
         chk({vt[v].name, "_seq"}, got, vt[v].seq);
         chk({vt[v].name, "_len"}, 64'(obs_n), 64'(vt[v].len));
         chk({vt[v].name, "_pt"},
             64'({obs_ov[vt[v].ci].flagw, obs_ov[vt[v].ci].alu, obs_ov[vt[v].ci].regw}),
             64'({vt[v].fw, 1'b0, vt[v].alu, vt[v].regw}));
`ifdef MC_CONTROL_MUL_EN
         if (vt[v].ismul == 4'h9) begin
            n_mst = 0;
            for (int i = 0; i < obs_n; i++) n_mst += int'(obs_ov[i].mst);
            chk({vt[v].name, "_mulstart_cnt"}, 64'(n_mst), 64'(1));
         end
`endif
      end

      reset_abort(2'b01, 6'b011001, 4'h0, 4);   // LDR, reset in MEMWB

`ifdef MC_CONTROL_MUL_EN
      exec_instr(2'b00, 6'b000000, 4'h0, 4'h9, 0);   // MulDone never comes
      chk("timeout_len", 64'(obs_n), 64'(2 + 1 + TO));
      #1;
      chk("timeout_fetch", 64'(state), 64'(0));
      chk("mulerr_set", 64'(MulErr), 64'(1));
      exec_instr(2'b00, 6'b001001, 4'h0, 4'h0, 0);   // MulErr stays sticky
      chk("mulerr_sticky", 64'(MulErr), 64'(1));
      reset_abort(2'b00, 6'b000000, 4'h9, 4);   // reset in MULWAIT clears MulErr
      chk("mulerr_cleared", 64'(MulErr), 64'(0));
`endif

      for (int n = 0; n < 200; n++) begin
         logic [1:0] op;
         logic [5:0] fn;
         logic [3:0] rd, ism;
         op = 2'($urandom_range(0, 3));
         fn = 6'($urandom);
         if ($urandom_range(0, 2) == 0) fn[5:1] = 5'b00000;
         ism = $urandom_range(0, 1) ? 4'h9 : 4'($urandom);
         rd = $urandom_range(0, 1) ? 4'hF : 4'($urandom);
         exec_instr(op, fn, rd, ism, int'($urandom_range(0, 20)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
